// File: rtl/ofs_plat_prim_burst_pkg.sv
// Shared burst-count encoding constants and the burstcount-to-beats conversion
// used by the multi-channel SOP/EOP tracker.
package ofs_plat_prim_burst_pkg;

  localparam int BURST_ORIGIN_AXI    = 0;
  localparam int BURST_ORIGIN_AVALON = 1;

  // Wide enough for any practical BURST_CNT_WIDTH plus the extra beat bit.
  localparam int MAX_BEAT_W = 33;
  typedef logic [MAX_BEAT_W-1:0] beat_cnt_t;

  // An illegal Avalon zero burst is tracked as a single beat so the stream
  // resynchronises on the next flit.
  function automatic beat_cnt_t burst_to_beats(input beat_cnt_t bc, input int origin);
    if (origin == BURST_ORIGIN_AVALON)
      return (bc == '0) ? beat_cnt_t'(1) : bc;
    return bc + beat_cnt_t'(1);
  endfunction

endpackage

// File: rtl/ofs_plat_prim_burst_chan_ctr.sv
// Per-channel burst position state: in-burst flag, flits remaining and the
// beat index of the next flit on this channel.
module ofs_plat_prim_burst_chan_ctr #(
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              upd,
  input  logic [BEAT_W-1:0] beats,
  output logic              sop,
  output logic              eop,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              in_burst,
  output logic              in_burst_nxt
);

  logic [BEAT_W-1:0] flits_rem;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] flits_rem_nxt;
  logic [BEAT_W-1:0] beat_cnt_nxt;

  assign sop      = ~in_burst;
  assign eop      = sop ? (beats == BEAT_W'(1)) : (flits_rem == BEAT_W'(1));
  assign beat_idx = sop ? '0 : beat_cnt;

  always_comb begin
    in_burst_nxt  = in_burst;
    flits_rem_nxt = flits_rem;
    beat_cnt_nxt  = beat_cnt;
    if (upd) begin
      if (eop) begin
        in_burst_nxt  = 1'b0;
        flits_rem_nxt = '0;
        beat_cnt_nxt  = '0;
      end else if (sop) begin
        in_burst_nxt  = 1'b1;
        flits_rem_nxt = beats - BEAT_W'(1);
        beat_cnt_nxt  = BEAT_W'(1);
      end else begin
        flits_rem_nxt = flits_rem - BEAT_W'(1);
        beat_cnt_nxt  = beat_cnt + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_burst  <= 1'b0;
      flits_rem <= '0;
      beat_cnt  <= '0;
    end else begin
      in_burst  <= in_burst_nxt;
      flits_rem <= flits_rem_nxt;
      beat_cnt  <= beat_cnt_nxt;
    end
  end

endmodule

// File: rtl/ofs_plat_prim_burstcount_sop_tracker_mc.sv
// Tracks start/end of burst independently for NUM_CHANNELS interleaved
// streams; reports SOP/EOP/beat index of the addressed flit combinationally.
module ofs_plat_prim_burstcount_sop_tracker_mc
  import ofs_plat_prim_burst_pkg::*;
#(
  parameter int BURST_CNT_WIDTH = 7,
  parameter int NUM_CHANNELS    = 1,
  parameter int BURST_ORIGIN    = 1,
  localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int BEAT_W = BURST_CNT_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flit_valid,
  input  logic [CHAN_W-1:0]          flit_chan,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  output logic                       sop,
  output logic                       eop,
  output logic [BEAT_W-1:0]          beat_idx,
  output logic [NUM_CHANNELS-1:0]    chan_in_burst,
  output logic                       idle,
  output logic                       err_zero_burst,
  output logic                       err_bad_chan
);

  // Every encodable channel number gets a slot; slots beyond NUM_CHANNELS
  // read as zero, which is exactly the required response to a bad channel.
  localparam int CHAN_SLOTS = 1 << CHAN_W;

  logic              chan_ok;
  logic              zero_burst;
  logic              any_in_burst_nxt;
  logic [BEAT_W-1:0] beats;
  logic              slot_sop    [CHAN_SLOTS];
  logic              slot_eop    [CHAN_SLOTS];
  logic [BEAT_W-1:0] slot_idx    [CHAN_SLOTS];
  logic              slot_ib     [CHAN_SLOTS];
  logic              slot_ib_nxt [CHAN_SLOTS];

  assign chan_ok = (32'(flit_chan) < NUM_CHANNELS);
  assign beats   = BEAT_W'(burst_to_beats(beat_cnt_t'(burstcount), BURST_ORIGIN));

  for (genvar i = 0; i < CHAN_SLOTS; i++) begin : g_chan
    if (i < NUM_CHANNELS) begin : g_ctr
      ofs_plat_prim_burst_chan_ctr #(
        .BEAT_W(BEAT_W)
      ) u_ctr (
        .clk          (clk),
        .reset_n      (reset_n),
        .upd          (flit_valid && chan_ok && (flit_chan == CHAN_W'(i))),
        .beats        (beats),
        .sop          (slot_sop[i]),
        .eop          (slot_eop[i]),
        .beat_idx     (slot_idx[i]),
        .in_burst     (slot_ib[i]),
        .in_burst_nxt (slot_ib_nxt[i])
      );
    end else begin : g_unused
      assign slot_sop[i]    = 1'b0;
      assign slot_eop[i]    = 1'b0;
      assign slot_idx[i]    = '0;
      assign slot_ib[i]     = 1'b0;
      assign slot_ib_nxt[i] = 1'b0;
    end
  end

  assign sop      = slot_sop[flit_chan];
  assign eop      = slot_eop[flit_chan];
  assign beat_idx = slot_idx[flit_chan];

  always_comb begin
    chan_in_burst    = '0;
    any_in_burst_nxt = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      chan_in_burst[i] = slot_ib[i];
      any_in_burst_nxt = any_in_burst_nxt | slot_ib_nxt[i];
    end
  end

  assign zero_burst = flit_valid && chan_ok && sop &&
                      (BURST_ORIGIN == BURST_ORIGIN_AVALON) && (burstcount == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle           <= 1'b1;
      err_zero_burst <= 1'b0;
      err_bad_chan   <= 1'b0;
    end else begin
      idle           <= ~any_in_burst_nxt;
      err_zero_burst <= err_zero_burst | zero_burst;
      err_bad_chan   <= err_bad_chan | (flit_valid && !chan_ok);
    end
  end

endmodule
